prga_decrypt_engine: RTL and testbench

PRGA_DECRYPT_ENGINE -- requirements
Module: prga_decrypt_engine

---
 rtl/rc4_pkg.sv | 22 ++
 rtl/prga_ascii_check.sv | 12 +
 rtl/prga_decrypt_engine.sv | 178 +++++++++++++++++
 tb/tb_prga_decrypt_engine.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA decrypt engine.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RD_I  = 4'd1,
    ST_LAT_I = 4'd2,
    ST_RD_J  = 4'd3,
    ST_LAT_J = 4'd4,
    ST_WR_J  = 4'd5,
    ST_WR_I  = 4'd6,
    ST_RD_F  = 4'd7,
    ST_OUT   = 4'd8,
    ST_NEXT  = 4'd9,
    ST_DONE  = 4'd10
  } prga_state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;

endpackage

// File: rtl/prga_ascii_check.sv
// Accepts lower-case letters 'a'..'z' and the space character.
module prga_ascii_check
  import rc4_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_pass
);

  assign o_pass = (i_byte == ASCII_SPACE) ||
                  ((i_byte >= ASCII_LO) && (i_byte <= ASCII_HI));

endmodule

// File: rtl/prga_decrypt_engine.sv
// RC4 PRGA over an externally keyed S memory; XORs the keystream with a message ROM
// and writes the plaintext out, optionally stopping at the first non-text byte.
module prga_decrypt_engine
  import rc4_pkg::*;
#(
  parameter  int MSG_DEP     = 32,
  parameter  int RAM_LAT     = 1,
  parameter  int CHECK_ASCII = 1,
  localparam int AW          = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [7:0]    s_addr,
  output logic [7:0]    s_wdata,
  output logic          s_wren,
  input  logic [7:0]    s_rdata,
  output logic [AW-1:0] msg_addr,
  input  logic [7:0]    msg_rdata,
  output logic [AW-1:0] out_addr,
  output logic [7:0]    out_data,
  output logic          out_wren,
  output logic          busy,
  output logic          done,
  output logic          msg_ok,
  output logic [AW-1:0] fail_idx,
  output logic [3:0]    dbg_state
);

  prga_state_t   r_state;
  logic [1:0]    r_wait;
  logic [7:0]    r_i, r_j, r_si, r_sj;
  logic [AW-1:0] r_k;
  logic [7:0]    r_s_addr, r_s_wdata;
  logic          r_s_wren;
  logic [AW-1:0] r_msg_addr, r_out_addr, r_fail_idx;
  logic          r_out_wren, r_busy, r_done, r_msg_ok, r_fail;

  logic [7:0]    w_out_data;
  logic          w_pass, w_lat_done, w_last;

  assign w_out_data = s_rdata ^ msg_rdata;
  assign w_lat_done = (r_wait == 2'(RAM_LAT - 1));
  assign w_last     = (r_k == AW'(MSG_DEP - 1));

  prga_ascii_check u_ascii (
    .i_byte (w_out_data),
    .o_pass (w_pass)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait     <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_si       <= '0;
      r_sj       <= '0;
      r_k        <= '0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_s_wren   <= 1'b0;
      r_msg_addr <= '0;
      r_out_addr <= '0;
      r_out_wren <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_msg_ok   <= 1'b0;
      r_fail_idx <= '0;
      r_fail     <= 1'b0;
    end else begin
      r_s_wren   <= 1'b0;
      r_out_wren <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state    <= ST_RD_I;
            r_i        <= 8'd1;
            r_j        <= '0;
            r_k        <= '0;
            r_wait     <= '0;
            r_s_addr   <= 8'd1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_msg_ok   <= 1'b0;
            r_fail_idx <= '0;
            r_fail     <= 1'b0;
          end
        end
        ST_RD_I: begin
          if (w_lat_done) begin
            r_wait  <= '0;
            r_state <= ST_LAT_I;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        ST_LAT_I: begin
          r_si     <= s_rdata;
          r_j      <= r_j + s_rdata;
          r_s_addr <= r_j + s_rdata;
          r_state  <= ST_RD_J;
        end
        ST_RD_J: begin
          if (w_lat_done) begin
            r_wait  <= '0;
            r_state <= ST_LAT_J;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        ST_LAT_J: begin
          r_sj      <= s_rdata;
          r_s_addr  <= r_j;
          r_s_wdata <= r_si;
          r_s_wren  <= 1'b1;
          r_state   <= ST_WR_J;
        end
        ST_WR_J: begin
          r_s_addr  <= r_i;
          r_s_wdata <= r_sj;
          r_s_wren  <= 1'b1;
          r_state   <= ST_WR_I;
        end
        // The keystream index uses the latched si/sj, so an i==j swap cannot disturb it.
        ST_WR_I: begin
          r_s_addr   <= r_si + r_sj;
          r_msg_addr <= r_k;
          r_state    <= ST_RD_F;
        end
        ST_RD_F: begin
          if (w_lat_done) begin
            r_wait     <= '0;
            r_out_addr <= r_k;
            r_out_wren <= 1'b1;
            r_state    <= ST_OUT;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        ST_OUT: begin
          r_fail  <= (CHECK_ASCII != 0) && !w_pass;
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (w_last || r_fail) begin
            r_state    <= ST_DONE;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_msg_ok   <= !r_fail;
            r_fail_idx <= r_fail ? r_k : '0;
          end else begin
            r_k      <= r_k + 1'b1;
            r_i      <= r_i + 8'd1;
            r_s_addr <= r_i + 8'd1;
            r_state  <= ST_RD_I;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign s_wren    = r_s_wren;
  assign msg_addr  = r_msg_addr;
  assign out_addr  = r_out_addr;
  // Read data arrives in OUT itself, so the plaintext byte is formed combinationally there.
  assign out_data  = r_out_wren ? w_out_data : 8'd0;
  assign out_wren  = r_out_wren;
  assign busy      = r_busy;
  assign done      = r_done;
  assign msg_ok    = r_msg_ok;
  assign fail_idx  = r_fail_idx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prga_decrypt_engine.sv
// Bench for prga_decrypt_engine: four parameterisations share one clock/reset, each
// backed by behavioural S memory, message ROM and output RAM models.
module tb_prga_decrypt_engine;

  localparam int NI = 4;
  localparam int D0 = 3,   L0 = 1, C0 = 0;
  localparam int D1 = 2,   L1 = 1, C1 = 1;
  localparam int D2 = 9,   L2 = 2, C2 = 0;
  localparam int D3 = 256, L3 = 3, C3 = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NI-1:0] start = '0;
  logic [NI-1:0] load_req = '0;

  wire [NI-1:0][7:0] s_addr, s_wdata, msg_addr, out_addr, out_data, fail_idx;
  wire [NI-1:0]      s_wren, out_wren, busy, done, msg_ok;
  wire [NI-1:0][3:0] dbg_state;
  logic [NI-1:0][7:0] s_rdata, msg_rdata;

  wire [1:0] ma0, oa0, fi0;
  wire [0:0] ma1, oa1, fi1;
  wire [3:0] ma2, oa2, fi2;
  wire [7:0] ma3, oa3, fi3;
  assign msg_addr[0] = 8'(ma0); assign out_addr[0] = 8'(oa0); assign fail_idx[0] = 8'(fi0);
  assign msg_addr[1] = 8'(ma1); assign out_addr[1] = 8'(oa1); assign fail_idx[1] = 8'(fi1);
  assign msg_addr[2] = 8'(ma2); assign out_addr[2] = 8'(oa2); assign fail_idx[2] = 8'(fi2);
  assign msg_addr[3] = ma3;     assign out_addr[3] = oa3;     assign fail_idx[3] = fi3;

  always #5 clk = ~clk;

  prga_decrypt_engine #(.MSG_DEP(D0), .RAM_LAT(L0), .CHECK_ASCII(C0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]),
    .s_wren(s_wren[0]), .s_rdata(s_rdata[0]), .msg_addr(ma0), .msg_rdata(msg_rdata[0]),
    .out_addr(oa0), .out_data(out_data[0]), .out_wren(out_wren[0]), .busy(busy[0]),
    .done(done[0]), .msg_ok(msg_ok[0]), .fail_idx(fi0), .dbg_state(dbg_state[0]));
  prga_decrypt_engine #(.MSG_DEP(D1), .RAM_LAT(L1), .CHECK_ASCII(C1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]),
    .s_wren(s_wren[1]), .s_rdata(s_rdata[1]), .msg_addr(ma1), .msg_rdata(msg_rdata[1]),
    .out_addr(oa1), .out_data(out_data[1]), .out_wren(out_wren[1]), .busy(busy[1]),
    .done(done[1]), .msg_ok(msg_ok[1]), .fail_idx(fi1), .dbg_state(dbg_state[1]));
  prga_decrypt_engine #(.MSG_DEP(D2), .RAM_LAT(L2), .CHECK_ASCII(C2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .s_addr(s_addr[2]), .s_wdata(s_wdata[2]),
    .s_wren(s_wren[2]), .s_rdata(s_rdata[2]), .msg_addr(ma2), .msg_rdata(msg_rdata[2]),
    .out_addr(oa2), .out_data(out_data[2]), .out_wren(out_wren[2]), .busy(busy[2]),
    .done(done[2]), .msg_ok(msg_ok[2]), .fail_idx(fi2), .dbg_state(dbg_state[2]));
  prga_decrypt_engine #(.MSG_DEP(D3), .RAM_LAT(L3), .CHECK_ASCII(C3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start[3]), .s_addr(s_addr[3]), .s_wdata(s_wdata[3]),
    .s_wren(s_wren[3]), .s_rdata(s_rdata[3]), .msg_addr(ma3), .msg_rdata(msg_rdata[3]),
    .out_addr(oa3), .out_data(out_data[3]), .out_wren(out_wren[3]), .busy(busy[3]),
    .done(done[3]), .msg_ok(msg_ok[3]), .fail_idx(fi3), .dbg_state(dbg_state[3]));

  function automatic int dep_of(input int g);
    case (g) 0: return D0; 1: return D1; 2: return D2; default: return D3; endcase
  endfunction
  function automatic int lat_of(input int g);
    case (g) 0: return L0; 1: return L1; 2: return L2; default: return L3; endcase
  endfunction
  function automatic bit ca_of(input int g);
    case (g) 0: return C0 != 0; 1: return C1 != 0; 2: return C2 != 0; default: return C3 != 0; endcase
  endfunction

  // ---------------- memory models ----------------
  logic [7:0] s_mem   [NI][256];
  logic [7:0] s_init  [NI][256];
  logic [7:0] msg_rom [NI][256];
  logic [7:0] out_mem [NI][256];
  logic [7:0] s_pipe  [NI][3];
  logic [7:0] m_pipe  [NI][3];
  int out_cnt [NI];
  int wr_cnt  [NI];

  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      s_pipe[g][0] <= s_mem[g][s_addr[g]];
      m_pipe[g][0] <= msg_rom[g][msg_addr[g]];
      for (int p = 1; p < 3; p++) begin
        s_pipe[g][p] <= s_pipe[g][p-1];
        m_pipe[g][p] <= m_pipe[g][p-1];
      end
      if (load_req[g]) begin
        for (int x = 0; x < 256; x++) s_mem[g][x] <= s_init[g][x];
        out_cnt[g] <= 0;
        wr_cnt[g]  <= 0;
      end else begin
        if (s_wren[g]) begin
          s_mem[g][s_addr[g]] <= s_wdata[g];
          wr_cnt[g] <= wr_cnt[g] + 1;
        end
        if (out_wren[g]) begin
          out_mem[g][out_addr[g]] <= out_data[g];
          out_cnt[g] <= out_cnt[g] + 1;
        end
      end
    end
  end

  always_comb begin
    for (int g = 0; g < NI; g++) begin
      s_rdata[g]   = s_pipe[g][lat_of(g) - 1];
      msg_rdata[g] = m_pipe[g][lat_of(g) - 1];
    end
  end

  // ---------------- scoreboard and reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] p_s   [256];
  logic [7:0] m_s   [256];
  logic [7:0] m_msg [256];
  bit m_ok;
  int m_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Straight RC4 PRGA over the model arrays; stops after the first non-text byte when asked.
  task automatic model_run(input int n, input bit ascii);
    int i = 0;
    int j = 0;
    int t;
    logic [7:0] o;
    exp_q.delete();
    m_ok   = 1'b1;
    m_fail = 0;
    for (int k = 0; k < n; k++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      t = int'(m_s[i]); m_s[i] = m_s[j]; m_s[j] = 8'(t);
      o = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256] ^ m_msg[k];
      exp_q.push_back(o);
      if (ascii && !(o == 8'h20 || (o >= 8'h61 && o <= 8'h7A))) begin
        m_ok = 1'b0; m_fail = k;
        break;
      end
    end
  endtask

  task automatic identity_s();
    for (int x = 0; x < 256; x++) p_s[x] = 8'(x);
  endtask

  task automatic rand_perm();
    int r;
    logic [7:0] t;
    identity_s();
    for (int x = 255; x > 0; x--) begin
      r = int'($urandom_range(x, 0));
      t = p_s[x]; p_s[x] = p_s[r]; p_s[r] = t;
    end
  endtask

  task automatic ksa_key();
    logic [7:0] key [3];
    logic [7:0] t;
    int j = 0;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    identity_s();
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(p_s[i]) + int'(key[i % 3])) % 256;
      t = p_s[i]; p_s[i] = p_s[j]; p_s[j] = t;
    end
  endtask

  task automatic load(input int g);
    @(negedge clk); load_req[g] = 1'b1;
    @(negedge clk); load_req[g] = 1'b0;
  endtask

  task automatic prepare(input int g);
    for (int x = 0; x < 256; x++) begin
      s_init[g][x]  = p_s[x];
      msg_rom[g][x] = m_msg[x];
      m_s[x]        = p_s[x];
    end
    load(g);
    model_run(dep_of(g), ca_of(g));
  endtask

  // cyc counts edges from the one sampling start (1) to the one where done is seen high.
  task automatic run(input int g, input int extra, output int cyc);
    @(negedge clk); start[g] = 1'b1;
    @(posedge clk); #1; start[g] = 1'b0;
    cyc = 1;
    chk($sformatf("busy_after_start%0d", g), 64'(busy[g]), 64'd1);
    chk($sformatf("done_low_after_start%0d", g), 64'(done[g]), 64'd0);
    while (!done[g] && cyc < 6000) begin
      @(posedge clk); #1;
      start[g] = 1'b0;
      cyc++;
      if (cyc == extra) start[g] = 1'b1;
    end
    if (!done[g]) chk($sformatf("done_timeout%0d", g), 64'd0, 64'd1);
  endtask

  task automatic check_result(input int g, input int cyc, input string tag);
    int n = exp_q.size();
    logic [7:0] e;
    chk({tag, "_cycles"}, 64'(cyc), 64'(n * (3 * lat_of(g) + 6) + 1));
    chk({tag, "_count"}, 64'(out_cnt[g]), 64'(n));
    chk({tag, "_msg_ok"}, 64'(msg_ok[g]), 64'(m_ok));
    chk({tag, "_fail_idx"}, 64'(fail_idx[g]), 64'(m_fail));
    chk({tag, "_busy_low"}, 64'(busy[g]), 64'd0);
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_out%0d", tag, k), 64'(out_mem[g][k]), 64'(e));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int         g;
    int         kind;
    int         nw;
    logic [7:0] msg [9];
    logic [7:0] exp [9];
    bit         ok;
    int         fidx;
    int         cyc;
  } vec_t;

  vec_t vt [3];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] pt;
    logic [71:0] ct;
    logic [7:0]  pool [8];
    int cyc;

    pt = "Plaintext";
    ct = 72'hBBF316E8D940AF0AD3;
    pool = '{8'h20, 8'h1F, 8'h21, 8'h60, 8'h61, 8'h7A, 8'h7B, 8'h6D};
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 9; k++) begin vt[r].msg[k] = 8'h00; vt[r].exp[k] = 8'h00; end
    vt[0].g = 0; vt[0].kind = 0; vt[0].nw = 3; vt[0].ok = 1'b1; vt[0].fidx = 0; vt[0].cyc = 28;
    vt[0].exp[0] = 8'h02; vt[0].exp[1] = 8'h05; vt[0].exp[2] = 8'h07;
    vt[1].g = 1; vt[1].kind = 0; vt[1].nw = 2; vt[1].ok = 1'b0; vt[1].fidx = 1; vt[1].cyc = 19;
    vt[1].msg[0] = 8'h63; vt[1].msg[1] = 8'h04; vt[1].exp[0] = 8'h61; vt[1].exp[1] = 8'h01;
    vt[2].g = 2; vt[2].kind = 1; vt[2].nw = 9; vt[2].ok = 1'b1; vt[2].fidx = 0; vt[2].cyc = 109;
    for (int k = 0; k < 9; k++) begin
      vt[2].msg[k] = ct[8*(8-k) +: 8];
      vt[2].exp[k] = pt[8*(8-k) +: 8];
    end

    // reset state
    #3;
    for (int g = 0; g < NI; g++)
      chk($sformatf("reset_outputs%0d", g),
          64'({s_addr[g], s_wdata[g], s_wren[g], msg_addr[g], out_addr[g], out_data[g],
               out_wren[g], busy[g], done[g], msg_ok[g], fail_idx[g]}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // table-driven known answers
    for (int r = 0; r < 3; r++) begin
      if (vt[r].kind == 0) identity_s(); else ksa_key();
      for (int x = 0; x < 256; x++) m_msg[x] = 8'h00;
      for (int k = 0; k < 9; k++) m_msg[k] = vt[r].msg[k];
      prepare(vt[r].g);
      run(vt[r].g, 0, cyc);
      chk($sformatf("vec%0d_cycles", r), 64'(cyc), 64'(vt[r].cyc));
      chk($sformatf("vec%0d_count", r), 64'(out_cnt[vt[r].g]), 64'(vt[r].nw));
      chk($sformatf("vec%0d_msg_ok", r), 64'(msg_ok[vt[r].g]), 64'(vt[r].ok));
      chk($sformatf("vec%0d_fail_idx", r), 64'(fail_idx[vt[r].g]), 64'(vt[r].fidx));
      for (int k = 0; k < vt[r].nw; k++)
        chk($sformatf("vec%0d_out%0d", r, k), 64'(out_mem[vt[r].g][k]), 64'(vt[r].exp[k]));
    end
    chk("vec0_s2", 64'(s_mem[0][2]), 64'h03);
    chk("vec0_s3", 64'(s_mem[0][3]), 64'h05);
    chk("vec0_s5", 64'(s_mem[0][5]), 64'h02);

    // reset during WR_J of byte 1 (byte 0 takes 9 cycles, WR_J is offset 4)
    identity_s();
    for (int x = 0; x < 256; x++) m_msg[x] = 8'h00;
    prepare(0);
    @(negedge clk); start[0] = 1'b1;
    @(posedge clk); #1; start[0] = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    chk("midrst_in_wr_j", 64'(dbg_state[0]), 64'd5);
    chk("midrst_wren_before", 64'(s_wren[0]), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_outputs_zero",
        64'({s_addr[0], s_wdata[0], s_wren[0], msg_addr[0], out_addr[0], out_data[0],
             out_wren[0], busy[0], done[0], msg_ok[0], fail_idx[0]}), 64'd0);
    chk("midrst_state_idle", 64'(dbg_state[0]), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_s_writes", 64'(wr_cnt[0]), 64'd2);
    chk("midrst_out_writes", 64'(out_cnt[0]), 64'd1);
    chk("midrst_s1_untouched", 64'(s_mem[0][1]), 64'h01);
    chk("midrst_still_idle", 64'(busy[0]), 64'd0);
    prepare(0);
    run(0, 0, cyc);
    check_result(0, cyc, "after_rst");

    // start while busy is ignored; start in DONE reruns with the same preload
    rand_perm();
    for (int x = 0; x < 256; x++) m_msg[x] = 8'($urandom_range(255, 0));
    prepare(0);
    run(0, 10, cyc);
    check_result(0, cyc, "busy_start");
    prepare(0);
    run(0, 0, cyc);
    check_result(0, cyc, "restart");

    // random permutations on instance 0 and the RAM_LAT=2 instance
    for (int t = 0; t < 6; t++) begin
      int g = (t < 4) ? 0 : 2;
      rand_perm();
      for (int x = 0; x < 256; x++) m_msg[x] = 8'($urandom_range(255, 0));
      prepare(g);
      run(g, 0, cyc);
      check_result(g, cyc, $sformatf("rand%0d", t));
    end

    // ascii boundary characters, encrypted by the model then decrypted by the DUT
    for (int t = 0; t < 10; t++) begin
      rand_perm();
      for (int x = 0; x < 256; x++) m_msg[x] = 8'h00;
      m_msg[0] = pool[$urandom_range(7, 0)];
      m_msg[1] = pool[$urandom_range(7, 0)];
      for (int x = 0; x < 256; x++) m_s[x] = p_s[x];
      model_run(2, 1'b0);
      m_msg[0] = exp_q[0];
      m_msg[1] = exp_q[1];
      prepare(1);
      run(1, 0, cyc);
      check_result(1, cyc, $sformatf("ascii%0d", t));
    end

    // 256-byte message: i wraps 255 -> 0 on the final byte
    identity_s();
    for (int x = 0; x < 256; x++) m_msg[x] = 8'($urandom_range(255, 0));
    prepare(3);
    run(3, 0, cyc);
    chk("dep256_pulses", 64'(out_cnt[3]), 64'd256);
    chk("dep256_cycles_abs", 64'(cyc), 64'(256 * 15 + 1));
    check_result(3, cyc, "dep256");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
